// File: rtl/gate_sweep_ctrl.sv
// ============================================================================
// gate_sweep_ctrl : manual forward / exhaustive sweep sequencer for gate network
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_ctrl #(
  parameter int VEC_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             mode,
  input  logic             start,
  input  logic [VEC_W-1:0] man_vec,
  input  logic [1:0]       dp_res,
  output logic [VEC_W-1:0] dp_vec,
  output logic             busy,
  output logic             done,
  output logic [VEC_W:0]   ones_cnt,
  output logic [7:0]       sig
);

  localparam int DW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [DW-1:0] C_DWELL_LAST = DW'(SETTLE_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_dwell;

  logic [VEC_W:0] w_ones_next;
  logic [7:0]     w_sig_next;
  logic           w_last_vec;

  assign w_ones_next = ones_cnt + (VEC_W+1)'(dp_res[0]);
  assign w_sig_next  = {sig[6:0], sig[7]} ^ {6'b0, dp_res};
  assign w_last_vec  = (dp_vec == {VEC_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dwell  <= '0;
      dp_vec   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= '0;
      sig      <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (!mode) begin
            // Leaving DONE keeps the results visible; only the done flag drops.
            r_state <= S_IDLE;
            done    <= 1'b0;
            dp_vec  <= man_vec;
          end else if (start) begin
            r_state  <= S_RUN;
            r_dwell  <= '0;
            dp_vec   <= '0;
            ones_cnt <= '0;
            sig      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        S_RUN: begin
          if (!mode) begin
            r_state  <= S_IDLE;
            r_dwell  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
            sig      <= '0;
            dp_vec   <= man_vec;
          end else if (r_dwell != C_DWELL_LAST) begin
            r_dwell <= r_dwell + DW'(1);
          end else begin
            // Sample cycle: the vector has settled for SETTLE_CYC cycles.
            ones_cnt <= w_ones_next;
            sig      <= w_sig_next;
            r_dwell  <= '0;
            if (w_last_vec) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              dp_vec <= dp_vec + VEC_W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ============================================================================
// tb_gate_sweep_ctrl : vector table, directed sweeps and randomized sweeps
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [7:0] man_vec = 8'h00;
  logic [1:0] dp_res;
  logic [7:0] dp_vec;
  logic       busy;
  logic       done;
  logic [8:0] ones_cnt;
  logic [7:0] sig;

  int n_vec = 0;
  int n_err = 0;
  int res_kind = 0;
  logic [1:0] res_tbl [256];

  gate_sweep_ctrl #(.VEC_W(8), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .start(start),
    .man_vec(man_vec), .dp_res(dp_res), .dp_vec(dp_vec), .busy(busy),
    .done(done), .ones_cnt(ones_cnt), .sig(sig)
  );

  always #5 clk = ~clk;

  // Gate network stand-in: result is a pure function of the applied vector.
  always_comb begin
    dp_res = 2'b00;
    case (res_kind)
      0: dp_res = 2'b01;
      1: dp_res = 2'b00;
      2: dp_res = {1'b0, dp_vec[0]};
      default: dp_res = res_tbl[dp_vec];
    endcase
  end

  function automatic logic [1:0] res_of(input int kind, input logic [7:0] v);
    case (kind)
      0: return 2'b01;
      1: return 2'b00;
      2: return {1'b0, v[0]};
      default: return res_tbl[v];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec"},  32'(dp_vec),   32'h0);
    check({tag, "_busy"}, 32'(busy),     32'h0);
    check({tag, "_done"}, 32'(done),     32'h0);
    check({tag, "_ones"}, 32'(ones_cnt), 32'h0);
    check({tag, "_sig"},  32'(sig),      32'h0);
  endtask

  // Full sweep: expected results from folding the result function over all vectors,
  // timing from vector index = active_edges / 3 and total = 768 + frozen cycles.
  task automatic run_sweep(input int kind, input int gap_len);
    int k, cnt, gap_at, gaps, exp_ones;
    logic [7:0] exp_sig, v;
    logic [1:0] r;
    res_kind = kind;
    exp_ones = 0;
    exp_sig  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      r = res_of(kind, v);
      exp_ones += int'(r[0]);
      exp_sig = {exp_sig[6:0], exp_sig[7]} ^ {6'b0, r};
    end
    mode = 1'b1; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'h1);
    check("start_done", 32'(done), 32'h0);
    check("start_ones", 32'(ones_cnt), 32'h0);
    check("start_sig",  32'(sig), 32'h0);
    gap_at = $urandom_range(10, 700);
    k = 0; cnt = 0; gaps = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      if (k % 3 == 0) check("sweep_vec", 32'(dp_vec), 32'(k / 3));
      if (k == gap_at && gaps < gap_len) begin
        ena = 1'b0;
        gaps++;
      end else begin
        ena = 1'b1;
      end
      tick();
      cnt++;
      if (ena) k++;
    end
    ena = 1'b1;
    check("busy_cycles", 32'(cnt), 32'(768 + gap_len));
    check("end_busy", 32'(busy), 32'h0);
    check("end_done", 32'(done), 32'h1);
    check("end_ones", 32'(ones_cnt), 32'(exp_ones));
    check("end_sig",  32'(sig), 32'(exp_sig));
    check("end_vec",  32'(dp_vec), 32'hFF);
  endtask

  typedef struct {
    logic       mode;
    logic       start;
    logic       ena;
    logic [7:0] man;
    logic [7:0] e_vec;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{mode:1'b0, start:1'b0, ena:1'b1, man:8'hA5, e_vec:8'hA5};
    tbl[1] = '{mode:1'b0, start:1'b1, ena:1'b1, man:8'h3C, e_vec:8'h3C};
    tbl[2] = '{mode:1'b0, start:1'b1, ena:1'b0, man:8'hFF, e_vec:8'h3C};
    tbl[3] = '{mode:1'b0, start:1'b1, ena:1'b1, man:8'hFF, e_vec:8'hFF};
    tbl[4] = '{mode:1'b1, start:1'b0, ena:1'b1, man:8'h00, e_vec:8'hFF};
    tbl[5] = '{mode:1'b0, start:1'b0, ena:1'b1, man:8'h00, e_vec:8'h00};
    tbl[6] = '{mode:1'b1, start:1'b1, ena:1'b0, man:8'h11, e_vec:8'h00};
    tbl[7] = '{mode:1'b0, start:1'b0, ena:1'b1, man:8'h11, e_vec:8'h11};
    for (int i = 0; i < 256; i++) res_tbl[i] = 2'($urandom);

    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_zero("post_reset");

    // Manual forwarding, ignored starts and clock-enable freeze
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode; start = tbl[i].start; ena = tbl[i].ena; man_vec = tbl[i].man;
      tick();
      check($sformatf("tbl%0d_vec", i), 32'(dp_vec), 32'(tbl[i].e_vec));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'h0);
      check($sformatf("tbl%0d_done", i), 32'(done), 32'h0);
    end
    start = 1'b0; ena = 1'b1;

    run_sweep(0, 0);
    mode = 1'b1;
    tick(); tick();
    check("done_hold", 32'(done), 32'h1);
    check("done_hold_ones", 32'(ones_cnt), 32'd256);
    mode = 1'b0; man_vec = 8'h77;
    tick();
    check("exit_done", 32'(done), 32'h0);
    check("exit_ones_held", 32'(ones_cnt), 32'd256);
    check("exit_vec", 32'(dp_vec), 32'h77);

    run_sweep(1, 0);
    run_sweep(2, 50);
    run_sweep(0, 0);

    // Abort part-way through a sweep
    res_kind = 0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    check("pre_abort_ones", 32'(ones_cnt), 32'd100);
    check("pre_abort_vec", 32'(dp_vec), 32'd100);
    mode = 1'b0; man_vec = 8'h5A;
    tick();
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_ones", 32'(ones_cnt), 32'h0);
    check("abort_sig", 32'(sig), 32'h0);
    check("abort_vec", 32'(dp_vec), 32'h5A);

    // Asynchronous reset mid-sweep, observed before the next clock edge
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (200) tick();
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(3, 0);

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) res_tbl[i] = 2'($urandom);
      run_sweep(3, int'($urandom_range(0, 60)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
